map_port_arbiter: RTL
=====================

Name: map_port_arbiter

Overview:
- Shares the single read port of the tile-map block RAM (19-bit address, 16-bit data) among several requesters: move-interaction logic, tile renderer, and future NPC/box logic.
- Grants one read per cycle and issues a registered address to the RAM.
- Routes the returned word back to the granted requester with a per-requester valid pulse.
- Supports locked bursts so the renderer can fetch consecutive tiles without interruption, bounded against starvation.

Parameters:
- NREQ, 3: number of requesters. Index 0 = renderer, 1 = interact, 2 = spare.
- ADDR_W, 19: map RAM address width.
- DATA_W, 16: map RAM data width.
- READ_LAT, 1: RAM read latency in cycles, with the RAM clocked on the inverted system clock.
- LOCK_MAX, 16: maximum consecutive grants to one locked owner.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester read request; held until acked.
- lock  in  NREQ  requester wants to keep the port after this grant.
- addr_in  in  NREQ*ADDR_W  flattened request addresses; slice i = requester i.
- ack  out  NREQ  combinational one-hot grant; transfer occurs on an edge where req[i]&ack[i].
- rvalid  out  NREQ  registered one-cycle pulse: data for requester i is on rdata.
- rdata  out  DATA_W  registered returned word, shared by all requesters.
- bram_addr  out  ADDR_W  registered address to the map RAM.
- bram_data  in  DATA_W  map RAM read data.

Behaviour:
- Reset values: bram_addr=0, rvalid=0, rdata=0, state=IDLE, owner=0, lock counter=0, RR pointer=0. ack is combinational and therefore 0 while sys_rst is high.
- At most one ack bit is high. ack[i] is only ever high while req[i] is high. An ack bit never asserts in a cycle where req is 0.
- Handshake: a requester keeps addr_in stable while req is high. The transfer completes at the edge with req&ack. The requester may then drop req or present the next address.
- Issue: at the transfer edge k, bram_addr <= addr_in slice of the winner. The winner's id is pushed into a (READ_LAT+1)-deep valid/id pipeline.
- Return: at edge k+1+READ_LAT, rdata <= bram_data and rvalid[id] <= 1 for exactly one cycle. Reads complete in issue order. The port sustains one read per cycle.
- Idle cycles (no req): bram_addr holds its last value and no pipeline entry is pushed.
- State IDLE:
  - The winner is chosen among req by the selection policy (see Optional Feature).
  - If the winner also has lock high at transfer, go to LOCKED with owner=winner and count=1.
- State LOCKED:
  - If req[owner] is high and count<LOCK_MAX, ack=owner regardless of other requests, and count increments on each transfer.
  - If lock[owner] is low at a transfer edge, that transfer is the last one; return to IDLE.
  - If req[owner] drops, go to IDLE on that edge, with no grant to the owner that cycle. Other requesters may be acked in the same cycle by policy.
  - If count==LOCK_MAX, forced release: return to IDLE, and for that cycle the owner is excluded from arbitration if any other req is high. If no other req is high, the owner may win again (new lock, count=1).
- Simultaneous rise of multiple req with no lock: exactly one is acked; the others remain pending with ack=0.
- Reset mid-operation: the pipeline is cleared. In-flight reads produce no rvalid. Requesters must re-request.
- The counter is $clog2(LOCK_MAX+1) bits wide and never wraps.

Optional Feature:
- Macro: MAP_ARB_RR_EN.
- Defined: round-robin. The search starts at the index one above the last granted index (mod NREQ). The pointer updates on every transfer edge.
- Undefined: fixed priority. The lowest asserted index wins (renderer first). The RR pointer logic is absent.

Test Plan:
- Single read: req=3'b010, addr_in[1]=0x00123 -> ack=3'b010 same cycle; bram_addr=0x00123 after the edge; rvalid=3'b010 with rdata=RAM[0x123] two edges later (READ_LAT=1).
- Contention, fixed priority: req=3'b011 held -> ack[0] first. With req[0] dropped after one transfer, ack[1] follows the next cycle. The rvalid order is 0 then 1.
- Burst: requester 0 with lock=1, addresses 0x100..0x103 back-to-back while req[1]=1 -> four consecutive acks to 0. lock drops on the 4th, then ack[1]. Four rvalid[0] pulses carry RAM[0x100..0x103] in order.
- Starvation bound: LOCK_MAX=16, requester 0 locked continuously with req[2]=1 -> after 16 grants, exactly one ack[2] is inserted, then owner 0 relocks.
- MAP_ARB_RR_EN defined, req=3'b111 held constantly -> ack sequence 0,1,2,0,1,2.
- Reset mid-flight: assert sys_rst the edge after a transfer -> no rvalid ever appears for it; all outputs return to reset values.

Source files
------------

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the tile-map BRAM read port among NREQ requesters with bounded locked bursts.
// Define MAP_ARB_RR_EN for round-robin selection; default build is fixed priority (renderer first).
module map_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] addr_in,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      bram_addr,
  input  logic [DATA_W-1:0]      bram_data
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  w_owner_oh, w_mask, w_grant;
  logic             w_hold, w_pick_any, w_any;
  logic [IDX_W-1:0] w_pick_idx, w_win;

  logic             r_vld_p [READ_LAT+1];
  logic [IDX_W-1:0] r_id_p  [READ_LAT+1];

  // A forced release hands the cycle to anyone else who is waiting
  always_comb begin
    w_owner_oh = NREQ'(1) << r_owner;
    w_hold     = (r_state == S_LOCKED) && req[r_owner] && (r_cnt < CNT_MAX);
    w_mask     = req;
    if ((r_state == S_LOCKED) && (r_cnt == CNT_MAX) && ((req & ~w_owner_oh) != '0))
      w_mask = req & ~w_owner_oh;
  end

`ifdef MAP_ARB_RR_EN
  localparam int SUM_W = IDX_W + 1;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    w_sum      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_W'(off);
      if (w_sum >= SUM_W'(NREQ))
        w_sum = w_sum - SUM_W'(NREQ);
      if (w_mask[w_sum[IDX_W-1:0]]) begin
        w_pick_any = 1'b1;
        w_pick_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst)
      r_rr_ptr <= '0;
    else if (w_any)
      r_rr_ptr <= (w_win == IDX_W'(NREQ - 1)) ? '0 : w_win + IDX_W'(1);
  end
`else
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_mask[i]) begin
        w_pick_any = 1'b1;
        w_pick_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_any       = w_hold | w_pick_any;
    w_win       = w_hold ? r_owner : w_pick_idx;
    w_grant     = w_any ? (NREQ'(1) << w_win) : '0;
    w_state_nxt = S_IDLE;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = '0;
    if (w_hold) begin
      if (lock[r_owner]) begin
        w_state_nxt = S_LOCKED;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end else if (w_pick_any && lock[w_pick_idx]) begin
      w_state_nxt = S_LOCKED;
      w_owner_nxt = w_pick_idx;
      w_cnt_nxt   = CNT_W'(1);
    end
  end

  assign ack = sys_rst ? '0 : w_grant;

  // Issue stage: address register plus id pipeline aligned to the RAM latency
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_cnt     <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      bram_addr <= '0;
      for (int j = 0; j <= READ_LAT; j++) begin
        r_vld_p[j] <= 1'b0;
        r_id_p[j]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_any)
        bram_addr <= addr_in[w_win*ADDR_W +: ADDR_W];
      r_vld_p[0] <= w_any;
      r_id_p[0]  <= w_win;
      for (int j = 1; j <= READ_LAT; j++) begin
        r_vld_p[j] <= r_vld_p[j-1];
        r_id_p[j]  <= r_id_p[j-1];
      end
      // Return stage
      rvalid <= r_vld_p[READ_LAT] ? (NREQ'(1) << r_id_p[READ_LAT]) : '0;
      if (r_vld_p[READ_LAT])
        rdata <= bram_data;
    end
  end
endmodule
